// File: rtl/mem_sparse_writer.sv
// rtl/mem_sparse_writer.sv - sparse-encoding write master for IFM/filter SRAMs
// Compresses dense beats into sparsemap + packed non-zero bytes with beat/chunk addressing.
module mem_sparse_writer #(
  parameter int BUS_SIZE  = 32,
  parameter int MEM_SIZE  = 128,
  parameter int CHUNK_NUM = 16,
  localparam int DAT_CYC_NUM = MEM_SIZE / BUS_SIZE,
  localparam int DW = $clog2(DAT_CYC_NUM),
  localparam int CW = $clog2(CHUNK_NUM),
  localparam int RW = $clog2(CHUNK_NUM + 1),
  localparam int NW = $clog2(BUS_SIZE + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [CW-1:0]         chunk_base_i,
  input  logic [RW-1:0]         chunk_num_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [BUS_SIZE*8-1:0] in_data_i,
  output logic [BUS_SIZE-1:0]   wr_sparsemap_o,
  output logic [BUS_SIZE*8-1:0] wr_nonzero_data_o,
  output logic                  wr_valid_o,
  output logic [DW-1:0]         wr_dat_count_o,
  output logic [CW-1:0]         wr_chunk_count_o,
  output logic [NW-1:0]         nz_count_o,
  output logic                  busy_o,
  output logic                  done_o
);

  typedef enum logic [1:0] {IDLE, RUN, LAST} state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   beat_q;
  logic [CW-1:0]   chunk_q;
  logic [RW-1:0]   remain_q;
  logic            hs, start_ok, done_d, chunk_end, last_beat;

  logic [BUS_SIZE-1:0]   map_d;
  logic [BUS_SIZE*8-1:0] packed_d;
  logic [NW-1:0]         nz_d;

  assign hs        = in_valid_i && in_ready_o;
  assign chunk_end = (beat_q == DW'(DAT_CYC_NUM - 1));
  assign last_beat = chunk_end && (remain_q == RW'(1));

  always_comb begin
    state_d  = state_q;
    start_ok = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (chunk_num_i != '0) begin
            start_ok = 1'b1;
            state_d  = RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (hs && last_beat) begin
          state_d = LAST;
          done_d  = 1'b1;
        end
      end
      LAST:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      beat_q   <= '0;
      chunk_q  <= '0;
      remain_q <= '0;
    end else if (start_ok) begin
      beat_q   <= '0;
      chunk_q  <= chunk_base_i;
      remain_q <= chunk_num_i;
    end else if (hs) begin
      if (chunk_end) begin
        beat_q   <= '0;
        chunk_q  <= (chunk_q == CW'(CHUNK_NUM - 1)) ? '0 : chunk_q + CW'(1);
        remain_q <= remain_q - RW'(1);
      end else begin
        beat_q <= beat_q + DW'(1);
      end
    end
  end

  // Prefix-sum compaction: each non-zero byte lands in the lane equal to the count of non-zero bytes below it.
  always_comb begin
    map_d    = '0;
    packed_d = '0;
    nz_d     = '0;
    for (int i = 0; i < BUS_SIZE; i++) begin
      map_d[i] = (in_data_i[i*8 +: 8] != 8'd0);
      if (map_d[i]) begin
        packed_d[nz_d*8 +: 8] = in_data_i[i*8 +: 8];
        nz_d = nz_d + NW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_valid_o        <= 1'b0;
      wr_sparsemap_o    <= '0;
      wr_nonzero_data_o <= '0;
      nz_count_o        <= '0;
      wr_dat_count_o    <= '0;
      wr_chunk_count_o  <= '0;
      in_ready_o        <= 1'b0;
      busy_o            <= 1'b0;
      done_o            <= 1'b0;
    end else begin
      wr_valid_o <= hs;
      if (hs) begin
        wr_sparsemap_o    <= map_d;
        wr_nonzero_data_o <= packed_d;
        nz_count_o        <= nz_d;
        wr_dat_count_o    <= beat_q;
        wr_chunk_count_o  <= chunk_q;
      end
      in_ready_o <= (state_d == RUN);
      busy_o     <= (state_d != IDLE);
      done_o     <= done_d;
    end
  end

endmodule

// File: tb/tb_mem_sparse_writer.sv
// tb/tb_mem_sparse_writer.sv - self-checking bench for mem_sparse_writer
// Directed and randomized transfers checked against a queue-based encoding model.
module tb_mem_sparse_writer;

  logic         clk_i, rst_i, start_i;
  logic [3:0]   chunk_base_i;
  logic [4:0]   chunk_num_i;
  logic         in_valid_i, in_ready_o;
  logic [255:0] in_data_i;
  logic [31:0]  wr_sparsemap_o;
  logic [255:0] wr_nonzero_data_o;
  logic         wr_valid_o;
  logic [1:0]   wr_dat_count_o;
  logic [3:0]   wr_chunk_count_o;
  logic [5:0]   nz_count_o;
  logic         busy_o, done_o;

  int checks = 0;
  int errors = 0;

  mem_sparse_writer #(.BUS_SIZE(32), .MEM_SIZE(128), .CHUNK_NUM(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .chunk_base_i(chunk_base_i), .chunk_num_i(chunk_num_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .wr_sparsemap_o(wr_sparsemap_o), .wr_nonzero_data_o(wr_nonzero_data_o),
    .wr_valid_o(wr_valid_o), .wr_dat_count_o(wr_dat_count_o),
    .wr_chunk_count_o(wr_chunk_count_o), .nz_count_o(nz_count_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] gen_beat(input int mode);
    logic [255:0] d;
    d = '0;
    for (int i = 0; i < 32; i++) begin
      if (mode == 1) d[i*8 +: 8] = 8'(i + 1);
      else if (mode == 3 && $urandom_range(1, 0) == 1) d[i*8 +: 8] = 8'($urandom_range(255, 1));
    end
    if (mode == 2) begin
      d[15:8]    = 8'hA1;
      d[47:40]   = 8'hB5;
      d[255:248] = 8'hFF;
    end
    return d;
  endfunction

  task automatic ref_encode(input logic [255:0] d, output logic [31:0] m,
                            output logic [255:0] p, output int n);
    logic [7:0] q[$];
    m = '0;
    p = '0;
    for (int i = 0; i < 32; i++) begin
      if (d[i*8 +: 8] != 8'd0) begin
        q.push_back(d[i*8 +: 8]);
        m[i] = 1'b1;
      end
    end
    n = q.size();
    for (int j = 0; j < n; j++) p[j*8 +: 8] = q[j];
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ready"}, 256'(in_ready_o), 256'(0));
    chk({tag, "_wr_valid"}, 256'(wr_valid_o), 256'(0));
    chk({tag, "_busy"}, 256'(busy_o), 256'(0));
    chk({tag, "_done"}, 256'(done_o), 256'(0));
    chk({tag, "_map"}, 256'(wr_sparsemap_o), 256'(0));
    chk({tag, "_data"}, wr_nonzero_data_o, 256'(0));
    chk({tag, "_dat"}, 256'(wr_dat_count_o), 256'(0));
    chk({tag, "_chunk"}, 256'(wr_chunk_count_o), 256'(0));
    chk({tag, "_nz"}, 256'(nz_count_o), 256'(0));
  endtask

  task automatic run_transfer(input int base, input int num, input int mode,
                              input int gap_pct, input bit noise);
    int total, k, budget, n;
    logic hs;
    logic [255:0] d, p;
    logic [31:0] m;
    total = num * 4;
    k = 0;
    budget = 0;
    start_i = 1'b1;
    chunk_base_i = 4'(base);
    chunk_num_i = 5'(num);
    step();
    start_i = 1'b0;
    if (num == 0) begin
      chk("zero_done", 256'(done_o), 256'(1));
      chk("zero_busy", 256'(busy_o), 256'(0));
      chk("zero_wr_valid", 256'(wr_valid_o), 256'(0));
      chk("zero_ready", 256'(in_ready_o), 256'(0));
      step();
      chk("zero_done_after", 256'(done_o), 256'(0));
      chk("zero_wr_valid_after", 256'(wr_valid_o), 256'(0));
      return;
    end
    chk("start_ready", 256'(in_ready_o), 256'(1));
    chk("start_busy", 256'(busy_o), 256'(1));
    chk("start_wr_valid", 256'(wr_valid_o), 256'(0));
    while (k < total && budget < 1000) begin
      budget++;
      in_valid_i = ($urandom_range(99, 0) >= gap_pct);
      d = gen_beat(mode);
      in_data_i = d;
      start_i = noise && ($urandom_range(3, 0) == 0);
      chunk_base_i = 4'($urandom_range(15, 0));
      chunk_num_i = 5'($urandom_range(16, 0));
      hs = in_valid_i && in_ready_o;
      chk("run_ready", 256'(in_ready_o), 256'(1));
      step();
      chk("wr_valid", 256'(wr_valid_o), 256'(hs));
      if (hs) begin
        ref_encode(d, m, p, n);
        chk("map", 256'(wr_sparsemap_o), 256'(m));
        chk("data", wr_nonzero_data_o, p);
        chk("nz", 256'(nz_count_o), 256'(n));
        chk("dat_count", 256'(wr_dat_count_o), 256'(k % 4));
        chk("chunk_count", 256'(wr_chunk_count_o), 256'((base + k / 4) % 16));
        chk("done_align", 256'(done_o), 256'(k == total - 1));
        if (mode == 2 && k == 0) begin
          chk("sparse_map_const", 256'(wr_sparsemap_o), 256'(32'h8000_0022));
          chk("sparse_nz_const", 256'(nz_count_o), 256'(3));
          chk("sparse_data_const", wr_nonzero_data_o, 256'(24'hFF_B5_A1));
        end
        k++;
      end else begin
        chk("gap_done", 256'(done_o), 256'(0));
      end
    end
    start_i = 1'b0;
    in_valid_i = 1'b0;
    if (k < total) chk("timeout_beats", 256'(k), 256'(total));
    chk("last_ready", 256'(in_ready_o), 256'(0));
    chk("last_busy", 256'(busy_o), 256'(1));
    step();
    chk("end_busy", 256'(busy_o), 256'(0));
    chk("end_done", 256'(done_o), 256'(0));
    chk("end_wr_valid", 256'(wr_valid_o), 256'(0));
    chk("end_ready", 256'(in_ready_o), 256'(0));
  endtask

  initial begin
    rst_i = 1'b1;
    start_i = 1'b0;
    chunk_base_i = '0;
    chunk_num_i = '0;
    in_valid_i = 1'b0;
    in_data_i = '0;
    step();
    step();
    check_zero("reset");

    start_i = 1'b1;
    chunk_base_i = 4'd1;
    chunk_num_i = 5'd1;
    step();
    check_zero("rst_start");
    rst_i = 1'b0;
    start_i = 1'b0;
    step();

    run_transfer(3, 1, 0, 0, 1'b0);
    run_transfer(7, 1, 1, 0, 1'b0);
    run_transfer(2, 1, 2, 0, 1'b0);
    run_transfer(15, 2, 3, 30, 1'b1);
    run_transfer(9, 0, 0, 0, 1'b0);

    start_i = 1'b1;
    chunk_base_i = 4'd5;
    chunk_num_i = 5'd2;
    step();
    start_i = 1'b0;
    in_valid_i = 1'b1;
    in_data_i = gen_beat(3);
    step();
    step();
    rst_i = 1'b1;
    step();
    check_zero("mid_rst");
    rst_i = 1'b0;
    in_valid_i = 1'b0;
    step();
    check_zero("post_rst");
    run_transfer(0, 1, 3, 20, 1'b0);

    for (int r = 0; r < 6; r++)
      run_transfer($urandom_range(15, 0), $urandom_range(3, 1), 3, 25, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
